mem_bus_initiator: RTL and testbench

Processor-side initiator for the tagged memory bus, i.e. the `proc2mem_*` / `mem2proc_*` protocol. It accepts load and store requests from one client over a valid/ready handshake and drives `BUS_LOAD`/`BUS_STORE` commands, retrying while the memory refuses them. It records the transaction tag of each accepted load and matches returning tags back to the client's request ID. It sits between the cache/fetch logic and `mem`, and replaces hand-driven bus stimulus in system benches.

---
 rtl/mem_bus_initiator.sv | 150 +++++++++++++++
 tb/tb_mem_bus_initiator.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_initiator.sv
// rtl/mem_bus_initiator.sv - tagged memory bus initiator with load tag table
// Optional sticky protocol checker built when MEM_BUS_ERR_CHECK_EN is defined.
module mem_bus_initiator #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ID_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  logic [31:0]     req_addr,
  input  logic [63:0]     req_data,
  input  logic [ID_W-1:0] req_id,
  output logic [1:0]      proc2mem_command,
  output logic [31:0]     proc2mem_addr,
  output logic [63:0]     proc2mem_data,
  input  logic [3:0]      mem2proc_response,
  input  logic [63:0]     mem2proc_data,
  input  logic [3:0]      mem2proc_tag,
  output logic            rsp_valid,
  output logic [63:0]     rsp_data,
  output logic [ID_W-1:0] rsp_id,
  output logic [3:0]      outstanding,
  output logic            err
);

  localparam logic [3:0] MAX_CNT   = 4'(MAX_OUTSTANDING);
  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                     state;
  logic                       issue_store;
  logic [ID_W-1:0]            issue_id;
  logic [MAX_OUTSTANDING-1:0] ent_valid;
  logic [3:0]                 ent_tag [MAX_OUTSTANDING];
  logic [ID_W-1:0]            ent_id  [MAX_OUTSTANDING];

  logic                       accepted;
  logic                       take_req;
  logic                       alloc_do;
  logic                       free_do;
  logic [MAX_OUTSTANDING-1:0] alloc_oh;
  logic [MAX_OUTSTANDING-1:0] free_oh;
  logic [ID_W-1:0]            free_id;

  // Both searches scan downward so the lowest matching index wins; they only
  // look at entries as they stand at the start of the cycle.
  always_comb begin
    accepted  = (state == ISSUE) && (mem2proc_response != 4'd0);
    req_ready = ((state == IDLE) || accepted) && (outstanding < MAX_CNT);
    take_req  = req_valid && req_ready;
    alloc_oh  = '0;
    free_oh   = '0;
    free_id   = '0;
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
      if (!ent_valid[i]) begin
        alloc_oh    = '0;
        alloc_oh[i] = 1'b1;
      end
      if (ent_valid[i] && (mem2proc_tag != 4'd0) && (ent_tag[i] == mem2proc_tag)) begin
        free_oh    = '0;
        free_oh[i] = 1'b1;
        free_id    = ent_id[i];
      end
    end
    alloc_do = accepted && !issue_store && (alloc_oh != '0);
    free_do  = (free_oh != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      proc2mem_command <= BUS_NONE;
      proc2mem_addr    <= '0;
      proc2mem_data    <= '0;
      issue_store      <= 1'b0;
      issue_id         <= '0;
      ent_valid        <= '0;
      rsp_valid        <= 1'b0;
      rsp_data         <= '0;
      rsp_id           <= '0;
      outstanding      <= '0;
    end else begin
      if (take_req) begin
        state            <= ISSUE;
        proc2mem_command <= req_store ? BUS_STORE : BUS_LOAD;
        proc2mem_addr    <= req_addr;
        proc2mem_data    <= req_data;
        issue_store      <= req_store;
        issue_id         <= req_id;
      end else if (accepted) begin
        state            <= IDLE;
        proc2mem_command <= BUS_NONE;
      end

      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (alloc_do && alloc_oh[i]) begin
          ent_valid[i] <= 1'b1;
          ent_tag[i]   <= mem2proc_response;
          ent_id[i]    <= issue_id;
        end else if (free_oh[i]) begin
          ent_valid[i] <= 1'b0;
        end
      end

      rsp_valid <= free_do;
      if (free_do) begin
        rsp_data <= mem2proc_data;
        rsp_id   <= free_id;
      end

      if (alloc_do && !free_do) begin
        outstanding <= outstanding + 4'd1;
      end else if (free_do && !alloc_do) begin
        outstanding <= outstanding - 4'd1;
      end
    end
  end

`ifdef MEM_BUS_ERR_CHECK_EN
  logic err_q;
  logic dup_tag;

  always_comb begin
    dup_tag = 1'b0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (ent_valid[i] && (ent_tag[i] == mem2proc_response)) dup_tag = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (((mem2proc_tag != 4'd0) && !free_do) ||
                 (accepted && !issue_store && dup_tag) ||
                 ((state == IDLE) && (mem2proc_response != 4'd0))) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_initiator.sv
// tb/tb_mem_bus_initiator.sv - self-checking bench for mem_bus_initiator
module tb_mem_bus_initiator;

  localparam int MAX  = 4;
  localparam int ID_W = 4;
`ifdef MEM_BUS_ERR_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  logic            req_store;
  logic [31:0]     req_addr;
  logic [63:0]     req_data;
  logic [ID_W-1:0] req_id;
  logic [1:0]      proc2mem_command;
  logic [31:0]     proc2mem_addr;
  logic [63:0]     proc2mem_data;
  logic [3:0]      mem2proc_response;
  logic [63:0]     mem2proc_data;
  logic [3:0]      mem2proc_tag;
  logic            rsp_valid;
  logic [63:0]     rsp_data;
  logic [ID_W-1:0] rsp_id;
  logic [3:0]      outstanding;
  logic            err;

  mem_bus_initiator #(.MAX_OUTSTANDING(MAX), .ID_W(ID_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_addr(req_addr), .req_data(req_data), .req_id(req_id),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data), .mem2proc_response(mem2proc_response),
    .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .outstanding(outstanding), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rv;
    logic [31:0] addr;
    logic [3:0]  id;
    logic [3:0]  resp;
    logic [3:0]  tag;
    logic [63:0] mdata;
    logic        exp_ready;
    logic [1:0]  exp_cmd;
    logic [31:0] exp_addr;
    logic        exp_rv;
    logic [3:0]  exp_id;
    logic [63:0] exp_rdata;
    logic [3:0]  exp_out;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [3:0] tag;
    logic [3:0] id;
  } ent_t;

  vec_t        tbl [10];
  ent_t        q [$];
  logic [63:0] mem_arr [logic [31:0]];
  logic [31:0] tag_addr [16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = 0; req_store = 0; req_addr = 0; req_data = 0; req_id = 0;
    mem2proc_response = 0; mem2proc_data = 0; mem2proc_tag = 0;
    reset = 1;
    tick();
    reset = 0;
  endtask

  // Handshake one request, then act as memory: accept in the first issue cycle.
  task automatic issue(input logic st, input logic [31:0] a, input logic [63:0] d,
                       input logic [3:0] id, input logic [3:0] rtag);
    req_valid = 1; req_store = st; req_addr = a; req_data = d; req_id = id;
    #1;
    chk("issue_ready", 64'(req_ready), 64'(1));
    tick();
    req_valid = 0;
    chk("issue_cmd", 64'(proc2mem_command), st ? 64'(2) : 64'(1));
    chk("issue_addr", 64'(proc2mem_addr), 64'(a));
    if (proc2mem_command == 2'd2) mem_arr[proc2mem_addr] = proc2mem_data;
    else tag_addr[rtag] = proc2mem_addr;
    mem2proc_response = rtag;
    tick();
    mem2proc_response = 0;
  endtask

  task automatic ret(input logic [3:0] t, input logic [63:0] d,
                     input logic [3:0] exp_id, input logic [63:0] exp_d);
    mem2proc_tag = t; mem2proc_data = d;
    tick();
    mem2proc_tag = 0;
    chk("ret_valid", 64'(rsp_valid), 64'(1));
    chk("ret_id", 64'(rsp_id), 64'(exp_id));
    chk("ret_data", rsp_data, exp_d);
  endtask

  function automatic bit in_q(input logic [3:0] t);
    foreach (q[j]) if (q[j].tag == t) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    // rv addr id resp tag mdata | ready cmd addr rv id rdata out err
    tbl[0] = '{1, 32'h100, 7, 0, 0, 64'h0,    1, 1, 32'h100, 0, 0, 64'h0,    0, 0};
    tbl[1] = '{1, 32'h108, 8, 5, 0, 64'h0,    1, 1, 32'h108, 0, 0, 64'h0,    1, 0};
    tbl[2] = '{0, 32'h0,   0, 6, 0, 64'h0,    1, 0, 32'h108, 0, 0, 64'h0,    2, 0};
    tbl[3] = '{1, 32'h110, 9, 0, 0, 64'h0,    1, 1, 32'h110, 0, 0, 64'h0,    2, 0};
    tbl[4] = '{0, 32'h0,   0, 9, 6, 64'hAAAA, 1, 0, 32'h110, 1, 8, 64'hAAAA, 2, 0};
    tbl[5] = '{0, 32'h0,   0, 0, 5, 64'hBBBB, 1, 0, 32'h110, 1, 7, 64'hBBBB, 1, 0};
    tbl[6] = '{0, 32'h0,   0, 0, 0, 64'h0,    1, 0, 32'h110, 0, 7, 64'hBBBB, 1, 0};
    tbl[7] = '{0, 32'h0,   0, 0, 9, 64'hCCCC, 1, 0, 32'h110, 1, 9, 64'hCCCC, 0, 0};
    tbl[8] = '{0, 32'h0,   0, 0, 12, 64'hDDDD, 1, 0, 32'h110, 0, 9, 64'hCCCC, 0, ERR_EN};
    tbl[9] = '{0, 32'h0,   0, 0, 0, 64'h0,    1, 0, 32'h110, 0, 9, 64'hCCCC, 0, ERR_EN};

    do_reset();
    tick();
    chk("rst_cmd", 64'(proc2mem_command), 64'(0));
    chk("rst_addr", 64'(proc2mem_addr), 64'(0));
    chk("rst_data", proc2mem_data, 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_data", rsp_data, 64'(0));
    chk("rst_rsp_id", 64'(rsp_id), 64'(0));
    chk("rst_outstanding", 64'(outstanding), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_ready", 64'(req_ready), 64'(1));

    // Out-of-order returns, simultaneous allocate/free, unmatched tag.
    for (int r = 0; r < 10; r++) begin
      req_valid = tbl[r].rv; req_store = 0; req_addr = tbl[r].addr; req_id = tbl[r].id;
      req_data = 0;
      mem2proc_response = tbl[r].resp; mem2proc_tag = tbl[r].tag; mem2proc_data = tbl[r].mdata;
      #1;
      chk($sformatf("tbl%0d_ready", r), 64'(req_ready), 64'(tbl[r].exp_ready));
      tick();
      chk($sformatf("tbl%0d_cmd", r), 64'(proc2mem_command), 64'(tbl[r].exp_cmd));
      chk($sformatf("tbl%0d_addr", r), 64'(proc2mem_addr), 64'(tbl[r].exp_addr));
      chk($sformatf("tbl%0d_rsp_valid", r), 64'(rsp_valid), 64'(tbl[r].exp_rv));
      chk($sformatf("tbl%0d_rsp_id", r), 64'(rsp_id), 64'(tbl[r].exp_id));
      chk($sformatf("tbl%0d_rsp_data", r), rsp_data, tbl[r].exp_rdata);
      chk($sformatf("tbl%0d_outstanding", r), 64'(outstanding), 64'(tbl[r].exp_out));
      chk($sformatf("tbl%0d_err", r), 64'(err), 64'(tbl[r].exp_err));
    end

    // Refusal retry: command held through three refusals.
    do_reset();
    req_valid = 1; req_store = 0; req_addr = 32'h40; req_id = 1;
    tick();
    req_valid = 0;
    for (int c = 0; c < 4; c++) begin
      mem2proc_response = (c == 3) ? 4'd3 : 4'd0;
      #1;
      chk($sformatf("retry%0d_cmd", c), 64'(proc2mem_command), 64'(1));
      chk($sformatf("retry%0d_addr", c), 64'(proc2mem_addr), 64'(32'h40));
      chk($sformatf("retry%0d_ready", c), 64'(req_ready), (c == 3) ? 64'(1) : 64'(0));
      chk($sformatf("retry%0d_out", c), 64'(outstanding), 64'(0));
      tick();
    end
    mem2proc_response = 0;
    chk("retry_alloc", 64'(outstanding), 64'(1));
    chk("retry_cmd_none", 64'(proc2mem_command), 64'(0));
    ret(3, 64'h4040, 1, 64'h4040);

    // Store/load round trip through the bench memory.
    issue(1, 32'h0, 64'd233, 0, 15);
    issue(1, 32'h4, 64'd996, 0, 15);
    issue(1, 32'h8, 64'd666, 0, 15);
    issue(0, 32'h0, 64'd0, 1, 1);
    issue(0, 32'h4, 64'd0, 2, 2);
    issue(0, 32'h8, 64'd0, 3, 3);
    chk("rt_out3", 64'(outstanding), 64'(3));
    ret(3, mem_arr[tag_addr[3]], 3, 64'd666);
    ret(1, mem_arr[tag_addr[1]], 1, 64'd233);
    ret(2, mem_arr[tag_addr[2]], 2, 64'd996);
    chk("rt_out0", 64'(outstanding), 64'(0));

    // Table full.
    for (int k = 0; k < 4; k++) issue(0, 32'h300 + 32'(k * 8), 64'd0, 4'(k + 4), 4'(k + 1));
    chk("full_out", 64'(outstanding), 64'(4));
    chk("full_ready", 64'(req_ready), 64'(0));
    ret(2, 64'h22, 5, 64'h22);
    chk("full_ready_after", 64'(req_ready), 64'(1));
    chk("full_out_after", 64'(outstanding), 64'(3));
    tick();
    chk("full_pulse_end", 64'(rsp_valid), 64'(0));
    ret(1, 64'h11, 4, 64'h11);
    ret(4, 64'h44, 7, 64'h44);
    ret(3, 64'h33, 6, 64'h33);
    chk("full_drain", 64'(outstanding), 64'(0));

    // Reset with two loads outstanding and a third mid-issue.
    issue(0, 32'h200, 64'd0, 1, 7);
    issue(0, 32'h208, 64'd0, 2, 8);
    chk("mid_out2", 64'(outstanding), 64'(2));
    req_valid = 1; req_store = 0; req_addr = 32'h210; req_id = 3;
    tick();
    req_valid = 0;
    reset = 1;
    tick();
    reset = 0;
    chk("mid_rst_out", 64'(outstanding), 64'(0));
    chk("mid_rst_cmd", 64'(proc2mem_command), 64'(0));
    chk("mid_rst_ready", 64'(req_ready), 64'(1));
    mem2proc_tag = 7; mem2proc_data = 64'h77;
    tick();
    mem2proc_tag = 0;
    chk("mid_old_tag_rsp", 64'(rsp_valid), 64'(0));
    chk("mid_old_tag_out", 64'(outstanding), 64'(0));
    tick();
    chk("mid_old_tag_err", 64'(err), 64'(ERR_EN));

    // Randomised traffic against a queue-based model of the tag table.
    do_reset();
    q.delete();
    begin
      logic        m_busy, m_store;
      logic [3:0]  m_id;
      logic [31:0] e_addr;
      logic [63:0] e_data, e_rdata;
      logic        e_rv, accept, e_ready, st, rv;
      logic [3:0]  e_rid, rsp_t, rt;
      int          k;
      m_busy = 0; m_store = 0; m_id = 0; e_addr = 0; e_data = 0;
      for (int n = 0; n < 400; n++) begin
        st = ($urandom_range(0, 2) == 0);
        rv = ($urandom_range(0, 1) == 1);
        if (!st && (q.size() + ((m_busy && !m_store) ? 1 : 0)) >= MAX) rv = 0;
        req_valid = rv; req_store = st; req_addr = $urandom; req_data = {$urandom, $urandom};
        req_id = 4'($urandom_range(0, 15));
        rsp_t = 0;
        if (m_busy && $urandom_range(0, 2) != 0) begin
          do rsp_t = 4'($urandom_range(1, 15)); while (in_q(rsp_t));
        end
        rt = 0; k = 0;
        if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
          k  = $urandom_range(0, q.size() - 1);
          rt = q[k].tag;
        end
        mem2proc_response = rsp_t; mem2proc_tag = rt; mem2proc_data = {$urandom, $urandom};
        #1;
        accept  = m_busy && (rsp_t != 0);
        e_ready = (!m_busy || accept) && (q.size() < MAX);
        chk("rnd_ready", 64'(req_ready), 64'(e_ready));
        e_rv = (rt != 0); e_rid = 0; e_rdata = 0;
        if (e_rv) begin
          e_rid = q[k].id; e_rdata = mem2proc_data;
          q.delete(k);
        end
        if (accept && !m_store) q.push_back('{tag: rsp_t, id: m_id});
        if (rv && e_ready) begin
          m_busy = 1; m_store = st; m_id = req_id; e_addr = req_addr; e_data = req_data;
        end else if (accept) begin
          m_busy = 0;
        end
        tick();
        chk("rnd_cmd", 64'(proc2mem_command), m_busy ? (m_store ? 64'(2) : 64'(1)) : 64'(0));
        chk("rnd_addr", 64'(proc2mem_addr), 64'(e_addr));
        chk("rnd_data", proc2mem_data, e_data);
        chk("rnd_rsp_valid", 64'(rsp_valid), 64'(e_rv));
        if (e_rv) begin
          chk("rnd_rsp_id", 64'(rsp_id), 64'(e_rid));
          chk("rnd_rsp_data", rsp_data, e_rdata);
        end
        chk("rnd_outstanding", 64'(outstanding), 64'(q.size()));
      end
    end
    mem2proc_response = 0; mem2proc_tag = 0; req_valid = 0;
    chk("rnd_no_err", 64'(err), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
